// File: rtl/dc_mem_ctrl.sv
// dc_mem_ctrl
// Memory-side controller that sits directly behind the data cache.
// It services the cache's word-at-a-time miss fills, absorbs 256-bit line
// writebacks into a small circular write buffer, and drains that buffer one
// word at a time to a variable-latency, word-wide memory port. A fill that
// hits a line still held in the buffer is never allowed to read stale memory.
//
// Optional feature (macro WB_FORWARD_EN):
//   defined   - a fill that hits the buffer is answered directly from the
//               youngest matching entry on the next cycle, with no memory access.
//   undefined - a hitting fill waits while the buffer drains until no match
//               remains, then a normal memory read is issued.
//
// Ports:
//   clk             system clock, all state on the rising edge
//   reset           asynchronous, active-low reset
//   is_request      cache fill request for the word at request_addr
//   request_addr    word address of the requested fill word
//   requested_data  fill word returned to the cache
//   fill_valid      one-cycle pulse: requested_data valid
//   is_wb           cache writeback push
//   wb_addr         line address of the writeback (bits [4:0] ignored)
//   wb_data         writeback line, word k = bits [32k+31:32k]
//   wb_full         write buffer full; a push while high is dropped
//   mem_req         memory transaction request, held until mem_ack
//   mem_we          1 = write, 0 = read
//   mem_addr        memory word address (bits [1:0] = 0)
//   mem_wdata       memory write word
//   mem_ack         memory completes the transaction this cycle
//   mem_rdata       memory read data, valid with mem_ack on reads

module dc_mem_ctrl #(
    parameter int WB_DEPTH = 4,
    parameter int PTR_W    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         is_request,
    input  logic [31:0]  request_addr,
    output logic [31:0]  requested_data,
    output logic         fill_valid,
    input  logic         is_wb,
    input  logic [31:0]  wb_addr,
    input  logic [255:0] wb_data,
    output logic         wb_full,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t           state_q, state_d;

    logic [26:0]      wb_tag_q  [WB_DEPTH];
    logic [255:0]     wb_line_q [WB_DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q, count_d;
    logic [2:0]       wcnt_q, wcnt_d;

    logic             push, pop, ack, start_drain;
    logic             hit;
    logic [PTR_W-1:0] hit_idx, scan_idx;

    logic             req_d, we_d, fill_d;
    logic [31:0]      addr_d, wdata_d, rdata_d;

    function automatic logic [31:0] line_word(input logic [255:0] line,
                                              input logic [2:0]   k);
        return line[{k, 5'd0} +: 32];
    endfunction

    assign push = is_wb && !wb_full;
    // An ack only counts while a transaction is actually outstanding.
    assign ack  = mem_ack && mem_req;

    // Hazard scan from oldest to youngest so the last hit is the youngest entry.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) && (wb_tag_q[scan_idx] == request_addr[31:5])) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    // Next-state and next-output logic. All memory-port outputs are registered,
    // so mem_ack never reaches mem_req combinationally.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        pop         = 1'b0;
        start_drain = 1'b0;
        req_d       = mem_req;
        we_d        = mem_we;
        addr_d      = mem_addr;
        wdata_d     = mem_wdata;
        rdata_d     = requested_data;
        fill_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_request && hit) begin
`ifdef WB_FORWARD_EN
                    rdata_d = line_word(wb_line_q[hit_idx], request_addr[4:2]);
                    fill_d  = 1'b1;
`else
                    // Flush buffered lines until the requested line is in memory.
                    start_drain = 1'b1;
`endif
                end else if (is_request && !wb_full) begin
                    state_d = FILL;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = {request_addr[31:2], 2'b00};
                end else if (count_q != '0) begin
                    start_drain = 1'b1;
                end
            end

            FILL: begin
                if (ack) begin
                    rdata_d = mem_rdata;
                    fill_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            DRAIN: begin
                // A line is always written out completely before anything else.
                if (ack) begin
                    if (wcnt_q == 3'd7) begin
                        pop     = 1'b1;
                        wcnt_d  = 3'd0;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        state_d = IDLE;
                    end else begin
                        wcnt_d  = wcnt_q + 3'd1;
                        addr_d  = {wb_tag_q[head_q], wcnt_q + 3'd1, 2'b00};
                        wdata_d = line_word(wb_line_q[head_q], wcnt_q + 3'd1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (start_drain) begin
            state_d = DRAIN;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = {wb_tag_q[head_q], 5'd0};
            wdata_d = line_word(wb_line_q[head_q], 3'd0);
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            wcnt_q         <= '0;
            wb_full        <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            requested_data <= '0;
            fill_valid     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            count_q        <= count_d;
            wb_full        <= (count_d == (PTR_W+1)'(WB_DEPTH));
            mem_req        <= req_d;
            mem_we         <= we_d;
            mem_addr       <= addr_d;
            mem_wdata      <= wdata_d;
            requested_data <= rdata_d;
            fill_valid     <= fill_d;
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
        end
    end

    // Buffer storage; validity is carried entirely by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_tag_q[tail_q]  <= wb_addr[31:5];
            wb_line_q[tail_q] <= wb_data;
        end
    end

`ifdef WB_FORWARD_EN
    logic unused_bits;
    assign unused_bits = ^{request_addr[1:0], wb_addr[4:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{request_addr[1:0], wb_addr[4:0], hit_idx};
`endif

endmodule

// File: tb/tb_dc_mem_ctrl.sv
module tb_dc_mem_ctrl;

    logic         clk;
    logic         reset;
    logic         is_request;
    logic [31:0]  request_addr;
    logic [31:0]  requested_data;
    logic         fill_valid;
    logic         is_wb;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    logic         wb_full;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    dc_mem_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .is_request     (is_request),
        .request_addr   (request_addr),
        .requested_data (requested_data),
        .fill_valid     (fill_valid),
        .is_wb          (is_wb),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .wb_full        (wb_full),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Memory model state
    int          lat    = 1;
    logic [31:0] rd_val = 32'h0;
    logic        spur   = 1'b0;
    int          mwait  = 0;
    logic        log_we   [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rd;
        int          lat;
        logic [31:0] exp_maddr;
        logic [31:0] exp_data;
        int          exp_cyc;
    } fill_vec_t;

    fill_vec_t vecs [4];

    // Variable-latency memory: acks after lat cycles of mem_req, logs each transaction.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack || !reset) begin
                mem_ack = 1'b0;
                mwait   = 0;
            end else if (mem_req) begin
                mwait++;
                if (mwait >= lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_we ? 32'h0 : rd_val;
                    log_we.push_back(mem_we);
                    log_addr.push_back(mem_addr);
                    log_data.push_back(mem_wdata);
                end
            end else if (spur) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h5555_5555;
                spur      = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    function automatic void get_log(input int i, output logic w,
                                    output logic [31:0] a, output logic [31:0] d);
        w = 1'b0;
        a = 32'h0;
        d = 32'h0;
        if (i < log_addr.size()) begin
            w = log_we[i];
            a = log_addr[i];
            d = log_data[i];
        end
    endfunction

    function automatic int n_reads();
        int n;
        n = 0;
        foreach (log_we[i]) if (!log_we[i]) n++;
        return n;
    endfunction

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    // Expect 8 writes of one line starting at log entry 'first'.
    task automatic chk_line(input string name, input int first,
                            input logic [31:0] la, input logic [255:0] line);
        logic        w;
        logic [31:0] a, d;
        for (int k = 0; k < 8; k++) begin
            get_log(first + k, w, a, d);
            // packed as {addr[31:2], we, 0, data}
            chk(name, {a[31:2], w, 1'b0, d},
                      {la[31:5], 3'(k), 1'b1, 1'b0, line[k*32 +: 32]});
        end
    endtask

    task automatic push_line(input logic [31:0] a, input logic [255:0] d);
        is_wb   = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(negedge clk);
        is_wb   = 1'b0;
    endtask

    // Hold a request until fill_valid is seen; cyc counts edges from the drive.
    task automatic do_fill(input logic [31:0] addr, output int cyc, output logic [31:0] data);
        logic seen;
        seen         = 1'b0;
        cyc          = 0;
        data         = 32'h0;
        is_request   = 1'b1;
        request_addr = addr;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (fill_valid) begin
                seen = 1'b1;
                data = requested_data;
            end
        end
        is_request = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int q, n;
        q = 0;
        n = 0;
        while (q < 4 && n < 3000) begin
            @(negedge clk);
            n++;
            if (!mem_req && dut.count_q == 0) q++;
            else q = 0;
        end
        chk(name, 64'(q >= 4), 64'd1);
    endtask

    task automatic wait_word(input logic [2:0] w, input logic need_ack, output logic ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 500) begin
            @(negedge clk);
            n++;
            if (mem_req && mem_we && mem_addr[4:2] == w && (!need_ack || mem_ack)) ok = 1'b1;
        end
    endtask

    initial begin
        int          cyc, n0, pulses;
        logic [31:0] data;
        logic        w, ok;
        logic [31:0] a, d;
        logic [255:0] hz_line;

        vecs[0] = '{32'h0000_1024, 32'hDEAD_BEEF, 3, 32'h0000_1024, 32'hDEAD_BEEF, 4};
        vecs[1] = '{32'h0000_1027, 32'h1234_5678, 1, 32'h0000_1024, 32'h1234_5678, 2};
        vecs[2] = '{32'hFFFF_FFFE, 32'hA5A5_A5A5, 2, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 3};
        vecs[3] = '{32'h8000_0010, 32'h0F0F_0F0F, 5, 32'h8000_0010, 32'h0F0F_0F0F, 6};

        reset        = 1'b0;
        is_request   = 1'b0;
        request_addr = 32'h0;
        is_wb        = 1'b0;
        wb_addr      = 32'h0;
        wb_data      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset ctrl outputs", {60'h0, mem_req, mem_we, fill_valid, wb_full}, 64'h0);
        chk("reset mem_addr", 64'(mem_addr), 64'h0);
        chk("reset mem_wdata", 64'(mem_wdata), 64'h0);
        chk("reset requested_data", 64'(requested_data), 64'h0);
        chk("reset count", 64'(dut.count_q), 64'h0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven fills from an empty buffer
        for (int i = 0; i < 4; i++) begin
            lat    = vecs[i].lat;
            rd_val = vecs[i].rd;
            clear_log();
            do_fill(vecs[i].addr, cyc, data);
            chk("fill latency", 64'(cyc), 64'(vecs[i].exp_cyc));
            chk("fill data", 64'(data), 64'(vecs[i].exp_data));
            @(negedge clk);
            chk("fill pulse width", 64'(fill_valid), 64'h0);
            chk("fill mem count", 64'(log_addr.size()), 64'd1);
            get_log(0, w, a, d);
            chk("fill mem addr/we", {31'h0, w, a}, {31'h0, 1'b0, vecs[i].exp_maddr});
        end

        // mem_ack with no outstanding request is ignored
        spur   = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (fill_valid) pulses++;
        end
        chk("spurious ack fill pulses", 64'(pulses), 64'h0);
        chk("spurious ack mem_req", 64'(mem_req), 64'h0);
        chk("spurious ack data held", 64'(requested_data), 64'h0F0F_0F0F);

        // Fill the buffer with 4 lines; 5th push dropped; drain order
        lat = 2;
        clear_log();
        push_line(32'h0000_0100, mk_line(32'h1000_0000));
        push_line(32'h0000_0200, mk_line(32'h2000_0000));
        push_line(32'h0000_0300, mk_line(32'h3000_0000));
        chk("wb_full before 4th push", 64'(wb_full), 64'h0);
        push_line(32'h0000_0400, mk_line(32'h4000_0000));
        chk("wb_full after 4th push", 64'(wb_full), 64'h1);
        push_line(32'h0000_0500, mk_line(32'h5000_0000));
        chk("wb_full after dropped push", 64'(wb_full), 64'h1);
        wait_quiet("drain4 timeout");
        chk("drain4 write count", 64'(log_addr.size()), 64'd32);
        chk_line("drain4 line 0x100", 0,  32'h0000_0100, mk_line(32'h1000_0000));
        chk_line("drain4 line 0x200", 8,  32'h0000_0200, mk_line(32'h2000_0000));
        chk_line("drain4 line 0x300", 16, 32'h0000_0300, mk_line(32'h3000_0000));
        chk_line("drain4 line 0x400", 24, 32'h0000_0400, mk_line(32'h4000_0000));
        chk("wb_full after drain", 64'(wb_full), 64'h0);

        // Fill that hits a buffered line
        lat    = 2;
        rd_val = 32'h2222_2222;
        clear_log();
        hz_line = mk_line(32'h7000_0000);
        hz_line[2*32 +: 32] = 32'hCAFE_F00D;
        push_line(32'h0000_2000, hz_line);
        do_fill(32'h0000_2008, cyc, data);
`ifdef WB_FORWARD_EN
        chk("forward latency", 64'(cyc), 64'd1);
        chk("forward data", 64'(data), 64'hCAFE_F00D);
        wait_quiet("forward drain timeout");
        chk("forward mem reads", 64'(n_reads()), 64'h0);
        chk("forward write count", 64'(log_addr.size()), 64'd8);
        chk_line("forward line 0x2000", 0, 32'h0000_2000, hz_line);
`else
        chk("hazard latency", 64'(cyc), 64'd27);
        chk("hazard data", 64'(data), 64'h2222_2222);
        wait_quiet("hazard drain timeout");
        chk("hazard mem count", 64'(log_addr.size()), 64'd9);
        chk_line("hazard line 0x2000", 0, 32'h0000_2000, hz_line);
        get_log(8, w, a, d);
        chk("hazard read after drain", {31'h0, w, a}, {31'h0, 1'b0, 32'h0000_2008});
`endif

        // Full buffer plus unrelated request: one whole line drains before the read
        lat    = 1;
        rd_val = 32'h3333_3333;
        clear_log();
        push_line(32'h0000_4000, mk_line(32'h4400_0000));
        push_line(32'h0000_4020, mk_line(32'h4420_0000));
        push_line(32'h0000_4040, mk_line(32'h4440_0000));
        push_line(32'h0000_4060, mk_line(32'h4460_0000));
        chk("full before request", 64'(wb_full), 64'h1);
        do_fill(32'h0000_9000, cyc, data);
        chk("full-case fill data", 64'(data), 64'h3333_3333);
        wait_quiet("full-case drain timeout");
        chk("full-case mem count", 64'(log_addr.size()), 64'd33);
        chk_line("full-case line 0x4000", 0, 32'h0000_4000, mk_line(32'h4400_0000));
        get_log(8, w, a, d);
        chk("full-case read position", {31'h0, w, a}, {31'h0, 1'b0, 32'h0000_9000});
        chk_line("full-case line 0x4020", 9,  32'h0000_4020, mk_line(32'h4420_0000));
        chk_line("full-case line 0x4040", 17, 32'h0000_4040, mk_line(32'h4440_0000));
        chk_line("full-case line 0x4060", 25, 32'h0000_4060, mk_line(32'h4460_0000));

        // Push coinciding with pop at count 2; 8 pushes wrap the pointers twice
        lat = 1;
        clear_log();
        push_line(32'h0000_5000, mk_line(32'h0A00_0000));
        push_line(32'h0000_5100, mk_line(32'h0A01_0000));
        chk("count after 2 pushes", 64'(dut.count_q), 64'd2);
        for (int j = 2; j < 8; j++) begin
            wait_word(3'd7, 1'b1, ok);
            chk("wait for last-word ack", 64'(ok), 64'h1);
            push_line(32'h0000_5000 + 32'(j) * 32'h100, mk_line(32'h0A00_0000 + 32'(j) * 32'h1_0000));
            chk("count after push+pop", 64'(dut.count_q), 64'd2);
        end
        wait_quiet("wrap drain timeout");
        chk("wrap write count", 64'(log_addr.size()), 64'd64);
        for (int j = 0; j < 8; j++)
            chk_line("wrap line order", j * 8, 32'h0000_5000 + 32'(j) * 32'h100,
                     mk_line(32'h0A00_0000 + 32'(j) * 32'h1_0000));

        // Reset in the middle of a line drain
        lat = 1;
        clear_log();
        push_line(32'h0000_6000, mk_line(32'h0B00_0000));
        push_line(32'h0000_6100, mk_line(32'h0B10_0000));
        wait_word(3'd3, 1'b0, ok);
        chk("wait for word 3", 64'(ok), 64'h1);
        reset = 1'b0;
        #1;
        chk("mem_req drops on reset", 64'(mem_req), 64'h0);
        n0 = log_addr.size();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("no writes after reset", 64'(log_addr.size()), 64'(n0));
        chk("wb_full after reset", 64'(wb_full), 64'h0);
        chk("count after reset", 64'(dut.count_q), 64'h0);
        chk("mem_req idle after reset", 64'(mem_req), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
